alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 78 +++++++
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encodings and the default datapath width.
// Latency: n/a (package). Backpressure: n/a.
// Contents: DATA_W_DEFAULT, alu_op_e (OP_ADD .. OP_NOP).
package alu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_SLT = 3'b101,
    OP_XOR = 3'b110,
    OP_NOP = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: op, a, b -> res (and zero/carry/overflow with ALU_FLAGS_EN).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: op[2:0], a/b[DATA_W-1:0] in; res[DATA_W-1:0] out; zero/carry/overflow out only if ALU_FLAGS_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
`ifdef ALU_FLAGS_EN
  ,
  output logic              zero,
  output logic              carry,
  output logic              overflow
`endif
);

  // With flags enabled the adder/subtractor carry one extra bit: the add
  // carry-out, or for subtraction the borrow (set exactly when a < b unsigned).
`ifdef ALU_FLAGS_EN
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
`else
  logic [DATA_W-1:0] sum_w;
  logic [DATA_W-1:0] diff_w;
  assign sum_w  = a + b;
  assign diff_w = a - b;
`endif

  logic slt_w;
  assign slt_w = ($signed(a) < $signed(b));

  always_comb begin
    res = '0;
    case (alu_op_e'(op))
      OP_ADD:  res = sum_w[DATA_W-1:0];
      OP_SUB:  res = diff_w[DATA_W-1:0];
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOT:  res = ~a;
      OP_SLT:  res = {{(DATA_W-1){1'b0}}, slt_w};
      OP_XOR:  res = a ^ b;
      OP_NOP:  res = '0;
      default: res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        carry    = sum_w[DATA_W];
        // Same-signed operands producing a result of the other sign.
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        carry    = diff_w[DATA_W];
        // Opposite-signed operands where the result sign differs from a.
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff_w[DATA_W-1] != a[DATA_W-1]);
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (res == '0);
`endif

endmodule

// File: rtl/alu.sv
// Registered ALU: A = zero-extended num1, B = B_CONST, result (and flags) registered.
// Latency: 1 cycle, a new op accepted every cycle. Backpressure: none (no handshake, no stall).
// Ports: clk, resetn (async active-low), op[2:0], num1[7:0] in; result[DATA_W-1:0] out;
//        zero/carry/overflow out only when macro ALU_FLAGS_EN is defined.
module alu
  import alu_pkg::*;
#(
  parameter int              DATA_W  = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] B_CONST = DATA_W'(32'h0000_0001)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [2:0]        op,
  input  logic [7:0]        num1,
  output logic [DATA_W-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic              zero,
  output logic              carry,
  output logic              overflow
`endif
);

  logic [DATA_W-1:0] a_w;
  logic [DATA_W-1:0] core_res;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] result_q;

  assign a_w = {{(DATA_W-8){1'b0}}, num1};

`ifdef ALU_FLAGS_EN
  logic core_zero, core_carry, core_overflow;
  logic zero_d, carry_d, overflow_d;
  logic zero_q, carry_q, overflow_q;
`endif

  alu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .op       (op),
    .a        (a_w),
    .b        (B_CONST),
    .res      (core_res)
`ifdef ALU_FLAGS_EN
    ,
    .zero     (core_zero),
    .carry    (core_carry),
    .overflow (core_overflow)
`endif
  );

  always_comb begin
    result_d = core_res;
  end

  // Async reset clears state immediately; an op sampled before reset is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef ALU_FLAGS_EN
  always_comb begin
    zero_d     = core_zero;
    carry_d    = core_carry;
    overflow_d = core_overflow;
  end

  // Flags reset to 0 alongside result, including zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, op sweep with random operands, async reset.
// Expected values come from constants or a reference model pushed to a scoreboard queue.
module tb_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [2:0]  op;
  logic [7:0]  num1;
  logic [31:0] result;
`ifdef ALU_FLAGS_EN
  logic        zero, carry, overflow;
`endif

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  alu dut (
    .clk      (clk),
    .resetn   (resetn),
    .op       (op),
    .num1     (num1),
    .result   (result)
`ifdef ALU_FLAGS_EN
    ,
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] n);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] wide;
    a = {24'd0, n};
    b = 32'h0000_0001;
    e = '0;
    case (o)
      3'd0: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[31:0];
        e.c   = wide[32];
        e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (a < b);
        e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = ~a;
      3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: e.res = a ^ b;
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk32({tag, ".result"}, result, e.res);
`ifdef ALU_FLAGS_EN
    chk1({tag, ".zero"}, zero, e.z);
    chk1({tag, ".carry"}, carry, e.c);
    chk1({tag, ".overflow"}, overflow, e.v);
`endif
  endtask

  // Drive on the falling edge, push the expectation, compare just after the next rising edge.
  task automatic step(input string tag, input logic [2:0] o, input logic [7:0] n, input exp_t e);
    exp_t got;
    @(negedge clk);
    op   = o;
    num1 = n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty observed=0 expected=1 entry", tag);
    end else begin
      got = sb.pop_front();
      chk_out(tag, got);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic c, input logic v);
    exp_t e;
    e.res = r;
    e.z   = z;
    e.c   = c;
    e.v   = v;
    return e;
  endfunction

  initial begin
    resetn = 1'b0;
    op     = 3'd0;
    num1   = 8'd0;
    #1;
    chk_out("reset_state", mk(32'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk32("reset_held", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors with hand-derived expectations (B = 1).
    step("add_ff",  3'd0, 8'hFF, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
    step("sub_00",  3'd1, 8'h00, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0));
    step("not_0f",  3'd4, 8'h0F, mk(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0));
    step("and_0f",  3'd2, 8'h0F, mk(32'h0000_0001, 1'b0, 1'b0, 1'b0));
    step("slt_00",  3'd5, 8'h00, mk(32'h0000_0001, 1'b0, 1'b0, 1'b0));
    step("slt_05",  3'd5, 8'h05, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0));
    step("nop",     3'd7, 8'hA5, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0));
    step("or_80",   3'd3, 8'h80, mk(32'h0000_0081, 1'b0, 1'b0, 1'b0));
    step("xor_01",  3'd6, 8'h01, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0));
    step("sub_05",  3'd1, 8'h05, mk(32'h0000_0004, 1'b0, 1'b0, 1'b0));

    // Inputs changing after the edge must not disturb the registered result.
    step("add_10",  3'd0, 8'h10, mk(32'h0000_0011, 1'b0, 1'b0, 1'b0));
    #1;
    op   = 3'd4;
    num1 = 8'h33;
    #1;
    chk32("hold_between_edges", result, 32'h0000_0011);

    // Op sweep every cycle with random operands against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int o = 0; o < 8; o++) begin
        logic [7:0] n;
        n = 8'($urandom_range(0, 255));
        step($sformatf("sweep_r%0d_op%0d", r, o), 3'(o), n, model(3'(o), n));
      end
    end

    // Async reset mid-cycle during an add: clears at once, holds, then resumes.
    step("pre_reset", 3'd0, 8'hFF, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    op   = 3'd0;
    num1 = 8'h10;
    #2;
    resetn = 1'b0;
    #1;
    chk_out("reset_immediate", mk(32'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk32("reset_hold_edge", result, 32'd0);
    @(negedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk32("reset_released_before_edge", result, 32'd0);
    @(posedge clk);
    #1;
    chk_out("first_after_reset", mk(32'h0000_0011, 1'b0, 1'b0, 1'b0));

    step("post_reset_sub", 3'd1, 8'h00, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
